matrix_det: RTL and testbench



---
 rtl/matrix_det_if.sv | 37 +++
 rtl/matrix_det.sv | 153 +++++++++++++++
 tb/tb_matrix_det.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/matrix_det_if.sv
// matrix_det bus: element beats in, determinant valid/ready out.
// Status flags ride along so one port carries the whole block.
interface matrix_det_if;
  logic               in_valid;
  logic signed [8:0]  in_real;
  logic signed [8:0]  in_image;
  logic               out_ready;
  logic               out_valid;
  logic signed [19:0] det_real;
  logic signed [19:0] det_image;
  logic               busy;
  logic               overrun;

  modport master (
    output in_valid,
    output in_real,
    output in_image,
    output out_ready,
    input  out_valid,
    input  det_real,
    input  det_image,
    input  busy,
    input  overrun
  );

  modport slave (
    input  in_valid,
    input  in_real,
    input  in_image,
    input  out_ready,
    output out_valid,
    output det_real,
    output det_image,
    output busy,
    output overrun
  );
endinterface

// File: rtl/matrix_det.sv
// 2x2 complex determinant C00*C11 - C01*C10 from four element beats,
// using one shared 9x9 signed multiplier over eight cycles.
module matrix_det (
  input  logic        clk,
  input  logic        rst,
  matrix_det_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    MUL,
    OUT
  } state_t;

  state_t state;
  state_t state_nxt;

  logic        [1:0]  idx;
  logic        [3:0]  k;
  logic signed [8:0]  el_r [4];
  logic signed [8:0]  el_i [4];
  logic signed [19:0] acc_r;
  logic signed [19:0] acc_i;
  logic signed [19:0] det_r;
  logic signed [19:0] det_i;
  logic               ovr;

  logic signed [8:0]  op_a;
  logic signed [8:0]  op_b;
  logic signed [17:0] prod;
  logic signed [19:0] prod_x;
  logic               mul_done;
  logic               drop;

  assign mul_done = (k == 4'd8);
  assign drop     = bus.in_valid &&
                    (state == MUL || state == OUT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (bus.in_valid) state_nxt = LOAD;
      end
      LOAD: begin
        if (bus.in_valid && idx == 2'd3)
          state_nxt = MUL;
      end
      MUL: begin
        if (mul_done) state_nxt = OUT;
      end
      OUT: begin
        if (bus.out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // k selects one of the eight partial products
  always_comb begin
    op_a = el_r[0];
    op_b = el_r[3];
    unique case (k[2:0])
      3'd0: begin op_a = el_r[0]; op_b = el_r[3]; end
      3'd1: begin op_a = el_i[0]; op_b = el_i[3]; end
      3'd2: begin op_a = el_r[0]; op_b = el_i[3]; end
      3'd3: begin op_a = el_i[0]; op_b = el_r[3]; end
      3'd4: begin op_a = el_r[1]; op_b = el_r[2]; end
      3'd5: begin op_a = el_i[1]; op_b = el_i[2]; end
      3'd6: begin op_a = el_r[1]; op_b = el_i[2]; end
      3'd7: begin op_a = el_i[1]; op_b = el_r[2]; end
      default: begin op_a = el_r[0]; op_b = el_r[3]; end
    endcase
  end

  assign prod   = op_a * op_b;
  assign prod_x = {{2{prod[17]}}, prod};

  always_ff @(posedge clk) begin
    if (rst) begin
      idx   <= 2'd0;
      k     <= 4'd0;
      acc_r <= 20'sd0;
      acc_i <= 20'sd0;
      det_r <= 20'sd0;
      det_i <= 20'sd0;
      ovr   <= 1'b0;
      for (int n = 0; n < 4; n++) begin
        el_r[n] <= 9'sd0;
        el_i[n] <= 9'sd0;
      end
    end else begin
      ovr <= drop;
      unique case (state)
        IDLE: begin
          if (bus.in_valid) begin
            el_r[0] <= bus.in_real;
            el_i[0] <= bus.in_image;
            idx     <= 2'd1;
          end
        end
        LOAD: begin
          if (bus.in_valid) begin
            el_r[idx] <= bus.in_real;
            el_i[idx] <= bus.in_image;
            idx       <= idx + 2'd1;
            k         <= 4'd0;
          end
        end
        MUL: begin
          if (mul_done) begin
            det_r <= acc_r;
            det_i <= acc_i;
            k     <= 4'd0;
          end else begin
            k <= k + 4'd1;
            unique case (k[2:0])
              3'd0: acc_r <= prod_x;
              3'd1: acc_r <= acc_r - prod_x;
              3'd2: acc_i <= prod_x;
              3'd3: acc_i <= acc_i + prod_x;
              3'd4: acc_r <= acc_r - prod_x;
              3'd5: acc_r <= acc_r + prod_x;
              3'd6: acc_i <= acc_i - prod_x;
              3'd7: acc_i <= acc_i - prod_x;
              default: acc_r <= acc_r;
            endcase
          end
        end
        OUT: begin
          idx <= 2'd0;
        end
        default: idx <= 2'd0;
      endcase
    end
  end

  assign bus.out_valid = (state == OUT);
  assign bus.busy      = (state == MUL) || (state == OUT);
  assign bus.overrun   = ovr;
  assign bus.det_real  = det_r;
  assign bus.det_image = det_i;

endmodule

// File: tb/tb_matrix_det.sv
// Directed and random checks of matrix_det against a complex-arithmetic
// reference model.
module tb_matrix_det;

  logic clk = 1'b0;
  logic rst;
  matrix_det_if bus ();

  matrix_det dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int ovr_cnt  = 0;
  int busy_cnt = 0;
  int mr [4];
  int mi [4];

  always @(negedge clk) begin
    if (bus.overrun === 1'b1) ovr_cnt++;
    if (bus.busy === 1'b1) busy_cnt++;
  end

  task automatic chk(input string tag,
                     input logic signed [63:0] obs,
                     input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input int r, input int i);
    bus.in_valid = 1'b1;
    bus.in_real  = 9'(r);
    bus.in_image = 9'(i);
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic send(input int gap);
    for (int n = 0; n < 4; n++) begin
      beat(mr[n], mi[n]);
      if (n < 3) repeat (gap) tick();
    end
  endtask

  task automatic set_m(input int a0, input int b0, input int a1,
                       input int b1, input int a2, input int b2,
                       input int a3, input int b3);
    mr[0] = a0; mi[0] = b0;
    mr[1] = a1; mi[1] = b1;
    mr[2] = a2; mi[2] = b2;
    mr[3] = a3; mi[3] = b3;
  endtask

  task automatic rand_m();
    for (int n = 0; n < 4; n++) begin
      mr[n] = int'($urandom_range(0, 511)) - 256;
      mi[n] = int'($urandom_range(0, 511)) - 256;
    end
  endtask

  // (a+bi)(c+di) products, then difference, in wide integers
  task automatic model(output longint dr, output longint di);
    longint p_r, p_i, q_r, q_i;
    p_r = longint'(mr[0]) * mr[3] - longint'(mi[0]) * mi[3];
    p_i = longint'(mr[0]) * mi[3] + longint'(mi[0]) * mr[3];
    q_r = longint'(mr[1]) * mr[2] - longint'(mi[1]) * mi[2];
    q_i = longint'(mr[1]) * mi[2] + longint'(mi[1]) * mr[2];
    dr = p_r - q_r;
    di = p_i - q_i;
  endtask

  task automatic wait_out(output int n);
    n = 0;
    while (bus.out_valid !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
  endtask

  task automatic check_det(input string tag, input int lat);
    longint dr, di;
    int n;
    model(dr, di);
    wait_out(n);
    chk({tag, "_valid"}, bus.out_valid, 1);
    chk({tag, "_re"}, bus.det_real, dr);
    chk({tag, "_im"}, bus.det_image, di);
    if (lat >= 0) chk({tag, "_lat"}, n, lat);
    if (bus.out_ready === 1'b1) begin
      tick();
      chk({tag, "_drop"}, bus.out_valid, 0);
    end
  endtask

  initial begin
    logic signed [19:0] hr, hi;
    int n;
    bus.in_valid  = 1'b0;
    bus.in_real   = '0;
    bus.in_image  = '0;
    bus.out_ready = 1'b1;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_valid", bus.out_valid, 0);
    chk("rst_re", bus.det_real, 0);
    chk("rst_im", bus.det_image, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_ovr", bus.overrun, 0);

    busy_cnt = 0;
    set_m(1, 0, 0, 0, 0, 0, 1, 0);
    send(0);
    check_det("ident", 9);
    chk("ident_busy", busy_cnt, 10);

    set_m(2, 3, 1, -1, 4, 0, -2, 5);
    send(1);
    chk("gen_busy0", bus.busy, 1);
    wait_out(n);
    chk("gen_re", bus.det_real, -23);
    chk("gen_im", bus.det_image, 8);
    tick();

    set_m(-256, -256, 255, 0, -256, 0, -256, -256);
    send(1);
    wait_out(n);
    chk("ext1_re", bus.det_real, 65280);
    chk("ext1_im", bus.det_image, 131072);
    tick();
    set_m(-256, -256, -256, 0, 255, 0, -256, -256);
    send(1);
    check_det("ext2", -1);
    set_m(-256, -256, -256, -256, -256, -256, -256, -256);
    send(0);
    check_det("ext3", 9);
    set_m(255, -256, -256, 255, 255, -256, -256, 255);
    send(0);
    check_det("ext4", 9);

    for (int r = 0; r < 6; r++) begin
      rand_m();
      send(r % 3);
      check_det("rand", -1);
    end

    bus.out_ready = 1'b0;
    ovr_cnt = 0;
    rand_m();
    send(1);
    check_det("bp", 9);
    hr = bus.det_real;
    hi = bus.det_image;
    for (int c = 0; c < 5; c++) begin
      if (c == 1 || c == 3) beat(7, -7);
      else tick();
      chk("bp_hold_v", bus.out_valid, 1);
      chk("bp_hold_re", bus.det_real, hr);
      chk("bp_hold_im", bus.det_image, hi);
    end
    tick();
    chk("bp_ovr", ovr_cnt, 2);
    bus.out_ready = 1'b1;
    tick();
    chk("bp_release", bus.out_valid, 0);
    rand_m();
    send(1);
    check_det("bp_next", -1);

    ovr_cnt = 0;
    rand_m();
    send(0);
    wait_out(n);
    beat(100, 100);
    chk("hs_drop_v", bus.out_valid, 0);
    chk("hs_drop_ovr", bus.overrun, 1);
    set_m(3, 0, 1, 1, 2, 0, 1, 2);
    send(0);
    check_det("hs_next", 9);
    chk("hs_ovr", ovr_cnt, 1);

    set_m(1, 0, 0, 0, 0, 0, 1, 0);
    send(0);
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mrst_valid", bus.out_valid, 0);
    chk("mrst_re", bus.det_real, 0);
    chk("mrst_im", bus.det_image, 0);
    chk("mrst_busy", bus.busy, 0);
    send(0);
    check_det("mrst_ident", 9);
    chk("mrst_ident_re", bus.det_real, 1);

    ovr_cnt = 0;
    for (int m = 0; m < 3; m++) begin
      rand_m();
      send(1);
      check_det("b2b", 9);
    end
    chk("b2b_ovr", ovr_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
